// File: rtl/ysyx_22040237_mcyc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding,
// halt codes and the default memory timeout.
package ysyx_22040237_mcyc_ctrl_pkg;

  localparam logic [3:0] ST_RST     = 4'd0;
  localparam logic [3:0] ST_IF_REQ  = 4'd1;
  localparam logic [3:0] ST_IF_WAIT = 4'd2;
  localparam logic [3:0] ST_ID      = 4'd3;
  localparam logic [3:0] ST_EX      = 4'd4;
  localparam logic [3:0] ST_LS_REQ  = 4'd5;
  localparam logic [3:0] ST_LS_WAIT = 4'd6;
  localparam logic [3:0] ST_WB      = 4'd7;
  localparam logic [3:0] ST_HALT    = 4'd8;

  typedef enum logic [3:0] {
    S_RST     = ST_RST,
    S_IF_REQ  = ST_IF_REQ,
    S_IF_WAIT = ST_IF_WAIT,
    S_ID      = ST_ID,
    S_EX      = ST_EX,
    S_LS_REQ  = ST_LS_REQ,
    S_LS_WAIT = ST_LS_WAIT,
    S_WB      = ST_WB,
    S_HALT    = ST_HALT
  } state_e;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_EBREAK  = 2'b01;
  localparam logic [1:0] HALT_INVALID = 2'b10;
  localparam logic [1:0] HALT_TIMEOUT = 2'b11;

  localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/ysyx_22040237_mcyc_ctrl_wait_timer.sv
// Memory-wait timer: cleared when a request phase starts, counts stalled
// wait cycles and saturates at its last value, which flags expiry.
module ysyx_22040237_wait_timer
  import ysyx_22040237_mcyc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] ONE  = TO_W'(1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear wins over increment, and the count never passes LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ysyx_22040237_mcyc_ctrl.sv
// Multi-cycle NPC sequencer (fetch/decode/execute/load-store/write-back).
// Optional performance counters are enabled with YSYX_22040237_PERF_CNT_EN.
module ysyx_22040237_mcyc_ctrl
  import ysyx_22040237_mcyc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 11
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  input  logic        dec_is_mem,
  input  logic        dec_ebreak,
  input  logic        dec_invalid,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        lsu_rsp_ready,
  output logic        ir_we,
  output logic        exu_en,
  output logic        rf_we_en,
  output logic        pc_we,
  output logic        halt,
  output logic [1:0]  halt_code
`ifdef YSYX_22040237_PERF_CNT_EN
  ,
  output logic [63:0] perf_cycle,
  output logic [63:0] perf_instret
`endif
);

  state_e     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic       tmr_clr_s, tmr_inc_s, tmr_expired_s;
  logic       wb_s;

  ysyx_22040237_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (tmr_clr_s),
    .inc_i     (tmr_inc_s),
    .expired_o (tmr_expired_s)
  );

  // Next-state and Moore step outputs; a response always beats a timeout.
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_rsp_ready = 1'b0;
    ir_we         = 1'b0;
    exu_en        = 1'b0;
    wb_s          = 1'b0;
    tmr_inc_s     = 1'b0;
    case (state_q)
      S_RST: state_d = S_IF_REQ;
      S_IF_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_d = S_IF_WAIT;
        else               state_d = S_IF_REQ;
      end
      S_IF_WAIT: begin
        ifu_rsp_ready = 1'b1;
        if (ifu_rsp_valid) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end else if (tmr_expired_s) begin
          state_d = S_HALT;
          code_d  = HALT_TIMEOUT;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      S_ID: begin
        if (dec_invalid) begin
          state_d = S_HALT;
          code_d  = HALT_INVALID;
        end else if (dec_ebreak) begin
          state_d = S_HALT;
          code_d  = HALT_EBREAK;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        exu_en = 1'b1;
        if (dec_is_mem) state_d = S_LS_REQ;
        else            state_d = S_WB;
      end
      S_LS_REQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) state_d = S_LS_WAIT;
        else               state_d = S_LS_REQ;
      end
      S_LS_WAIT: begin
        lsu_rsp_ready = 1'b1;
        if (lsu_rsp_valid) begin
          state_d = S_WB;
        end else if (tmr_expired_s) begin
          state_d = S_HALT;
          code_d  = HALT_TIMEOUT;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      S_WB: begin
        wb_s    = 1'b1;
        state_d = S_IF_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    tmr_clr_s = (state_d == S_IF_REQ) || (state_d == S_LS_REQ);
  end

  // A reset arriving during WB must suppress the architectural writes at once.
  assign rf_we_en  = wb_s & ~rst;
  assign pc_we     = wb_s & ~rst;
  assign halt      = (state_q == S_HALT);
  assign halt_code = code_q;

  // State and sticky halt-code registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      code_q  <= HALT_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

`ifdef YSYX_22040237_PERF_CNT_EN
  logic [63:0] cycle_q, instret_q;

  // Cycle and retired-instruction counters, frozen once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 64'd0;
      instret_q <= 64'd0;
    end else if (state_q != S_HALT) begin
      cycle_q   <= cycle_q + 64'd1;
      instret_q <= instret_q + {63'd0, wb_s};
    end else begin
      cycle_q   <= cycle_q;
      instret_q <= instret_q;
    end
  end

  assign perf_cycle   = cycle_q;
  assign perf_instret = instret_q;
`endif

endmodule

// File: tb/tb_ysyx_22040237_mcyc_ctrl.sv
// Self-checking bench for ysyx_22040237_mcyc_ctrl: the bench plays IFU/LSU with
// random handshake delays and predicts timing from per-step cycle arithmetic.
module tb_ysyx_22040237_mcyc_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_rsp_ready;
  logic        ir_we, exu_en, rf_we_en, pc_we, halt;
  logic [1:0]  halt_code;
  logic        ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic        lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic        dec_is_mem = 1'b0, dec_ebreak = 1'b0, dec_invalid = 1'b0;
`ifdef YSYX_22040237_PERF_CNT_EN
  logic [63:0] perf_cycle, perf_instret;
`endif

  ysyx_22040237_mcyc_ctrl #(.TIMEOUT_CYC(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .dec_is_mem(dec_is_mem), .dec_ebreak(dec_ebreak), .dec_invalid(dec_invalid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .ir_we(ir_we), .exu_en(exu_en), .rf_we_en(rf_we_en), .pc_we(pc_we),
    .halt(halt), .halt_code(halt_code)
`ifdef YSYX_22040237_PERF_CNT_EN
    , .perf_cycle(perf_cycle), .perf_instret(perf_instret)
`endif
  );

  always #5 clk = ~clk;

  logic [10:0] outs_s;
  assign outs_s = {ifu_req_valid, ifu_rsp_ready, lsu_req_valid, lsu_rsp_ready,
                   ir_we, exu_en, rf_we_en, pc_we, halt, halt_code};

  int errs = 0, checks = 0;
  int cyc = 0, pc_cnt = 0;
  int retired_total = 0, retired_here = 0, rel_cyc = 0, halt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pc_we) pc_cnt <= pc_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    dec_is_mem = 1'b0; dec_ebreak = 1'b0; dec_invalid = 1'b0;
  endtask

  task automatic check_perf_zero();
`ifdef YSYX_22040237_PERF_CNT_EN
    check_eq("perf_cycle_rst", perf_cycle, 64'd0);
    check_eq("perf_instret_rst", perf_instret, 64'd0);
`endif
  endtask

  // Leaves the DUT in its RST state with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_outs", outs_s, 11'd0);
    check_perf_zero();
    rst = 1'b0;
    rel_cyc = cyc;
    retired_here = 0;
  endtask

  // One instruction; caller must be at the cycle just before its IF_REQ.
  task automatic run_instr(input bit mem, input bit ebr, input bit inv,
                           input int a, input int b, input int c, input int d,
                           input bit if_to, input bit ls_to, input bit rst_mid);
    int t0;
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k <= a; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("ifu_req_valid", ifu_req_valid, 1'b1);
      check_eq("ifu_rsp_ready_in_req", ifu_rsp_ready, 1'b0);
      ifu_req_ready = (k == a);
    end
    @(negedge clk);
    ifu_req_ready = 1'b0;
    if (if_to) begin
      for (int k = 0; k < TO; k++) begin
        if (k > 0) @(negedge clk);
        check_eq("if_wait_no_halt", {ifu_rsp_ready, halt}, 2'b10);
      end
      @(negedge clk);
      halt_cyc = cyc;
      check_eq("if_timeout_halt", {halt, halt_code}, 3'b111);
      return;
    end
    for (int k = 0; k <= b; k++) begin
      if (k > 0) @(negedge clk);
      check_eq("ifu_rsp_ready", ifu_rsp_ready, 1'b1);
      ifu_rsp_valid = (k == b);
      #1;
      check_eq("ir_we", ir_we, (k == b));
    end
    @(negedge clk);
    ifu_rsp_valid = 1'b0;
    dec_is_mem = mem; dec_ebreak = ebr; dec_invalid = inv;
    check_eq("id_outs", outs_s, 11'd0);
    if (inv || ebr) begin
      @(negedge clk);
      halt_cyc = cyc;
      clear_inputs();
      check_eq("id_halt", {halt, halt_code}, {1'b1, (inv ? 2'b10 : 2'b01)});
      return;
    end
    @(negedge clk);
    dec_ebreak = 1'($urandom); dec_invalid = 1'($urandom);
    check_eq("exu_en", exu_en, 1'b1);
    if (mem) begin
      for (int k = 0; k <= c; k++) begin
        @(negedge clk);
        dec_is_mem = 1'($urandom);
        check_eq("lsu_req_valid", lsu_req_valid, 1'b1);
        lsu_req_ready = (k == c);
      end
      @(negedge clk);
      lsu_req_ready = 1'b0;
      if (ls_to) begin
        for (int k = 0; k < TO; k++) begin
          if (k > 0) @(negedge clk);
          check_eq("ls_wait_no_halt", {lsu_rsp_ready, halt}, 2'b10);
        end
        @(negedge clk);
        halt_cyc = cyc;
        clear_inputs();
        check_eq("ls_timeout_halt", {halt, halt_code}, 3'b111);
        return;
      end
      for (int k = 0; k <= d; k++) begin
        if (k > 0) @(negedge clk);
        check_eq("lsu_rsp_ready", lsu_rsp_ready, 1'b1);
        if (rst_mid && k == 1) begin
          rst = 1'b1;
          clear_inputs();
          @(negedge clk);
          check_eq("rst_mid_outs", outs_s, 11'd0);
          @(negedge clk);
          check_eq("rst_mid_outs2", outs_s, 11'd0);
          check_perf_zero();
          rst = 1'b0;
          rel_cyc = cyc;
          retired_here = 0;
          return;
        end
        lsu_rsp_valid = (k == d);
      end
    end
    @(negedge clk);
    clear_inputs();
    check_eq("wb_enables", {rf_we_en, pc_we}, 2'b11);
    check_eq("wb_latency", cyc - t0, 4 + a + b + (mem ? 2 + c + d : 0));
    retired_total++;
    retired_here++;
  endtask

  // HALT must absorb any input activity and hold every output.
  task automatic check_halt_frozen(input logic [1:0] code);
`ifdef YSYX_22040237_PERF_CNT_EN
    check_eq("perf_cycle_halt", perf_cycle, 64'(halt_cyc - rel_cyc));
    check_eq("perf_instret_halt", perf_instret, 64'(retired_here));
`endif
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ifu_req_ready = 1'($urandom); ifu_rsp_valid = 1'($urandom);
      lsu_req_ready = 1'($urandom); lsu_rsp_valid = 1'($urandom);
      dec_ebreak = 1'($urandom); dec_invalid = 1'($urandom);
      #1;
      check_eq("halt_frozen", outs_s, {8'd0, 1'b1, code});
    end
`ifdef YSYX_22040237_PERF_CNT_EN
    check_eq("perf_cycle_frozen", perf_cycle, 64'(halt_cyc - rel_cyc));
    check_eq("perf_instret_frozen", perf_instret, 64'(retired_here));
`endif
    clear_inputs();
  endtask

  initial begin
    int a, b, c, d;
    bit m;
    do_reset();
    repeat (3) run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 0, 0, 2, 3, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 1'b0, 1'b0, 0, TO - 1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 1, 0, 0, TO - 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom);
      a = int'($urandom_range(0, 3));
      b = ($urandom_range(0, 4) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      d = ($urandom_range(0, 4) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      run_instr(m, 1'b0, 1'b0, a, b, c, d, 1'b0, 1'b0, 1'b0);
    end
    run_instr(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_halt_frozen(2'b10);

    do_reset();
    repeat (4) run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    check_halt_frozen(2'b01);

    do_reset();
    run_instr(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    check_halt_frozen(2'b11);

    do_reset();
    run_instr(1'b1, 1'b0, 1'b0, 0, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    check_halt_frozen(2'b11);

    do_reset();
    run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 0, 0, 0, 3, 1'b0, 1'b0, 1'b1);
    run_instr(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check_eq("pc_we_total", pc_cnt, retired_total);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1);
  end

endmodule
